// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional statistics counters (stall/flush/bubble) are built when PIPE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int               INS_W   = 32,
  parameter int               SIDE_W  = 60,
  parameter logic [INS_W-1:0] NOP_INS = {INS_W{1'b0}},
  parameter int               CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  in_ins,
  input  logic [SIDE_W-1:0] in_side,
  input  logic              squash,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INS_W-1:0]  out_ins,
  output logic [SIDE_W-1:0] out_side
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [INS_W-1:0]  skid_ins_reg;
  logic [SIDE_W-1:0] skid_side_reg;

  logic              in_xfer;
  logic              out_xfer;
  logic [INS_W-1:0]  in_ins_eff;

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  // A squashed entry still travels down the pipe, carrying its PC sideband.
  assign in_ins_eff = squash ? NOP_INS : in_ins;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_EMPTY;
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
      out_ins       <= NOP_INS;
      out_side      <= '0;
      skid_ins_reg  <= NOP_INS;
      skid_side_reg <= '0;
    end else if (flush) begin
      // Sideband is left as-is; only the instruction is forced to a bubble.
      state_reg <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_ins   <= NOP_INS;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_reg <= ST_ONE;
            out_valid <= 1'b1;
            out_ins   <= in_ins_eff;
            out_side  <= in_side;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_ins  <= in_ins_eff;
            out_side <= in_side;
          end else if (in_xfer) begin
            state_reg     <= ST_TWO;
            in_ready      <= 1'b0;
            skid_ins_reg  <= in_ins_eff;
            skid_side_reg <= in_side;
          end else if (out_xfer) begin
            state_reg <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_reg <= ST_ONE;
            in_ready  <= 1'b1;
            out_ins   <= skid_ins_reg;
            out_side  <= skid_side_reg;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= sat_inc(stall_cnt);
      if (flush && (state_reg != ST_EMPTY || in_valid))
        flush_cnt <= sat_inc(flush_cnt);
      // A flush overrides a squash, so that entry is not a bubble.
      if (squash && in_xfer && !flush)
        bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg plus hand-written async-reset and statistics sequences.
module tb_pipe_stage_reg;

  localparam int INS_W  = 32;
  localparam int SIDE_W = 60;
  localparam int CNT_W  = 4;

  logic              Clk;
  logic              Reset;
  logic              in_valid;
  logic              in_ready;
  logic [INS_W-1:0]  in_ins;
  logic [SIDE_W-1:0] in_side;
  logic              squash;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [INS_W-1:0]  out_ins;
  logic [SIDE_W-1:0] out_side;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .INS_W  (INS_W),
    .SIDE_W (SIDE_W),
    .NOP_INS(32'd0),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ins   (in_ins),
    .in_side  (in_side),
    .squash   (squash),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ins  (out_ins),
    .out_side (out_side)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic              iv;
    logic [INS_W-1:0]  ins;
    logic [SIDE_W-1:0] side;
    logic              sq;
    logic              fl;
    logic              ordy;
    logic              exp_ov;
    logic              exp_ir;
    logic [INS_W-1:0]  exp_ins;
    logic [SIDE_W-1:0] exp_side;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [INS_W-1:0] ins,
                              input logic [SIDE_W-1:0] side, input logic sq,
                              input logic fl, input logic ordy, input logic exp_ov,
                              input logic exp_ir, input logic [INS_W-1:0] exp_ins,
                              input logic [SIDE_W-1:0] exp_side);
    vec_t v;
    v.iv = iv; v.ins = ins; v.side = side; v.sq = sq; v.fl = fl; v.ordy = ordy;
    v.exp_ov = exp_ov; v.exp_ir = exp_ir; v.exp_ins = exp_ins; v.exp_side = exp_side;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [INS_W-1:0] ins, input logic [SIDE_W-1:0] side,
                       input logic sq, input logic fl, input logic ordy);
    in_valid = iv; in_ins = ins; in_side = side; squash = sq; flush = fl; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming: one entry per cycle, one-cycle latency.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'h1000 + i, 60'(i), 0, 0, 1, 1, 1, 32'h1000 + i, 60'(i)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h1007, 60'd7));
    // Backpressure: A, B fill main/skid, C held off, then drain in order.
    vecs.push_back(mk(1, 32'h11, 60'hA, 0, 0, 0, 1, 1, 32'h11, 60'hA));
    vecs.push_back(mk(1, 32'h22, 60'hB, 0, 0, 0, 1, 0, 32'h11, 60'hA));
    vecs.push_back(mk(1, 32'h33, 60'hC, 0, 0, 0, 1, 0, 32'h11, 60'hA));
    vecs.push_back(mk(1, 32'h33, 60'hC, 0, 0, 1, 1, 1, 32'h22, 60'hB));
    vecs.push_back(mk(1, 32'h33, 60'hC, 0, 0, 1, 1, 1, 32'h33, 60'hC));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h33, 60'hC));
    // Flush while TWO with an incoming entry: nothing survives, sideband kept.
    vecs.push_back(mk(1, 32'h55, 60'h5, 0, 0, 0, 1, 1, 32'h55, 60'h5));
    vecs.push_back(mk(1, 32'h66, 60'h6, 0, 0, 0, 1, 0, 32'h55, 60'h5));
    vecs.push_back(mk(1, 32'h44, 60'h4, 0, 1, 0, 0, 1, 32'h0, 60'h5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 60'h5));
    // Squash: bubble that keeps its sideband.
    vecs.push_back(mk(1, 32'h8C010004, 60'h0000_1234_0000_5678, 1, 0, 0, 1, 1, 32'h0, 60'h0000_1234_0000_5678));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 60'h0000_1234_0000_5678));
    // Squash without a transfer does nothing.
    vecs.push_back(mk(0, 32'h77, 60'h7, 1, 0, 1, 0, 1, 32'h0, 60'h0000_1234_0000_5678));
    // Flush with squash and an incoming entry in EMPTY behaves as flush.
    vecs.push_back(mk(1, 32'h88, 60'h8, 1, 1, 1, 0, 1, 32'h0, 60'h0000_1234_0000_5678));
    // Flush in ONE concurrent with delivery.
    vecs.push_back(mk(1, 32'h99, 60'h9, 0, 0, 0, 1, 1, 32'h99, 60'h9));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 32'h0, 60'h9));

    // Reset state while Reset is asserted.
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_ins", out_ins, 0);
    check("reset_out_side", out_side, 0);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ins, vecs[i].side, vecs[i].sq, vecs[i].fl, vecs[i].ordy);
      tick();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      check($sformatf("v%0d_out_ins", i), out_ins, vecs[i].exp_ins);
      check($sformatf("v%0d_out_side", i), out_side, vecs[i].exp_side);
      $display("vec %0d: ov=%0b ir=%0b ins=0x%0h side=0x%0h", i, out_valid, in_ready, out_ins, out_side);
    end

    // Asynchronous reset while TWO, between clock edges.
    drive(1, 32'h71, 60'h71, 0, 0, 0);
    tick();
    drive(1, 32'h72, 60'h72, 0, 0, 0);
    tick();
    check("pre_reset_two_in_ready", in_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    #3;
    Reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_ins", out_ins, 0);
    check("async_rst_out_side", out_side, 0);
    #2;
    Reset = 1'b1;
    tick();
    check("post_rst_idle_valid", out_valid, 0);
    drive(1, 32'h99AA, 60'h3, 0, 0, 1);
    tick();
    check("post_rst_first_valid", out_valid, 1);
    check("post_rst_first_ins", out_ins, 32'h99AA);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    check("post_rst_drained", out_valid, 0);
    $display("async reset sequence done");

`ifdef PIPE_STATS_EN
    #2;
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    check("stats_reset_stall", stall_cnt, 0);
    drive(1, 32'h5, 60'h5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge Clk);
    #1;
    check("stall_cnt_saturated", stall_cnt, 4'hF);
    drive(1, 32'hABC, 60'h1, 1, 0, 1);
    repeat (3) @(posedge Clk);
    #1;
    check("bubble_cnt", bubble_cnt, 3);
    check("bubble_out_ins", out_ins, 0);
    check("flush_cnt_zero", flush_cnt, 0);
    drive(1, 32'hDEF, 60'h2, 1, 1, 0);
    tick();
    check("flush_cnt_one", flush_cnt, 1);
    check("bubble_cnt_after_flush", bubble_cnt, 3);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    $display("stats: stall=%0d flush=%0d bubble=%0d", stall_cnt, flush_cnt, bubble_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the PCPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops or duplicates an instruction.
- Supports flush (kill everything held) and squash (insert a bubble that keeps its sideband PC data).
- One instance per stage boundary; instruction and sideband widths are set per instance.

Parameters:
INS_W, 32, instruction field width
SIDE_W, 60, sideband payload width (default is PC[31:2] concatenated with B_PC[31:2])
NOP_INS, 32'd0, instruction value used for bubbles and at reset
CNT_W, 16, statistics counter width (used only when PIPE_STATS_EN is defined)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; driven directly from a register
in_ins  in  INS_W  incoming instruction
in_side  in  SIDE_W  incoming sideband (PC, branch PC)
squash  in  1  replace the instruction accepted this cycle with NOP_INS
flush  in  1  discard all held entries and the incoming entry
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_ins  out  INS_W  output instruction
out_side  out  SIDE_W  output sideband

Behaviour:
- Definitions: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register.
- State is EMPTY, ONE or TWO; out_valid = (state != EMPTY); in_ready = (state != TWO).
- Reset (asynchronous, Reset=0):
  - state EMPTY, out_valid 0, in_ready 1.
  - out_ins = NOP_INS, out_side = 0; skid contents = NOP_INS / 0.
- Reset may assert mid-operation, including in TWO; all entries are lost and no output glitches to valid.
- Latency: an in_xfer in EMPTY appears on out_* the next cycle. Throughput is 1 entry per cycle while out_ready=1.
- Transitions (no flush):
  - EMPTY: in_xfer -> ONE, main <= in.
  - ONE: in_xfer & out_xfer -> ONE, main <= in.
  - ONE: in_xfer only -> TWO, skid <= in.
  - ONE: out_xfer only -> EMPTY.
  - ONE: neither -> hold.
  - TWO: out_xfer -> ONE, main <= skid. in_ready=0, so no input is accepted.
  - TWO: no out_xfer -> hold. Both registers stay stable.
- Squash:
  - Applies only to an in_xfer in the same cycle.
  - The stored instruction is NOP_INS; the stored sideband is in_side; the entry is valid (a bubble that keeps its PC).
  - squash without in_xfer has no effect.
- Flush:
  - Highest priority over everything except reset.
  - Next state EMPTY; main out_ins <= NOP_INS; sideband unchanged.
  - An in_valid entry in the same cycle is discarded.
  - An out_xfer in the same cycle still counts as delivered.
- flush and squash together behave as flush alone.
- Ordering is strict FIFO: main is always older than skid.
- out_ins / out_side change only on a main-register load or a flush.

Optional Feature:
- Macro PIPE_STATS_EN.
- When defined, adds three output ports, each CNT_W wide, saturating at all-ones, cleared by Reset:
  - stall_cnt: +1 each cycle with out_valid & !out_ready.
  - flush_cnt: +1 each flush cycle with state != EMPTY or in_valid=1.
  - bubble_cnt: +1 each squashed in_xfer.
- When undefined, the ports and logic are absent and the datapath is identical.

Test Plan:
1. Streaming: out_ready=1, feed ins 0x1000+i for i=0..7 on consecutive cycles -> out_ins equals 0x1000+i one cycle after acceptance; out_valid continuous; in_ready stays 1.
2. Backpressure: feed A=0x11, B=0x22, C=0x33 with out_ready=0 -> A on out, B in skid, in_ready=0 while C is held. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
3. Flush in TWO, with Reset high throughout: A and B held, out_ready=0, flush=1 and in_valid=1 (C=0x44) -> next cycle out_valid=0, in_ready=1, out_ins=NOP_INS. A, B and C never appear on the output.
4. Squash: in_ins=0x8C010004, in_side=0x0000_1234_0000_5678, squash=1 -> out_ins=0x00000000, out_side=0x0000_1234_0000_5678, out_valid=1.
5. Reset mid-operation: in TWO, drop Reset asynchronously between clock edges -> out_valid=0 and in_ready=1 immediately, out_ins=NOP_INS. After release, the first accepted entry emerges with 1-cycle latency.
6. PIPE_STATS_EN with CNT_W=4: hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt saturates at 15. Apply 3 squashed transfers -> bubble_cnt=3.
